// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared encodings for the multi-cycle RV32I controller
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_EXECJALR = 4'd11,
    S_JALRLINK = 4'd12,
    S_LUI      = 4'd13
  } stateT;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format is a pure function of the opcode; anything not listed uses I.
  function automatic logic [2:0] immSrcFor(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps aluOp and funct fields to the ALU operation
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // opb5 separates R-type from I-type, so addi never turns into sub
          3'b000:  aluControl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b011:  aluControl = ALU_SLTU;
          3'b100:  aluControl = ALU_XOR;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the shared-memory multi-cycle RV32I datapath
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       lt,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] immSrc,
  output logic [2:0] aluControl
);

  stateT      state, nextState;
  logic       pcUpdate, branch, taken, rLegal;
  logic       adrSrcS, memWriteS, irWriteS, regWriteS;
  logic [1:0] resultSrcS, aluSrcAS, aluSrcBS, aluOp;
  logic [2:0] aluCtl;

  // Only base-ISA R-type encodings (funct7 0000000 / 0100000) are accepted.
  assign rLegal = ~(funct7[6] | (|funct7[4:0]));

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nextState;
  end

  always_comb begin
    nextState  = S_FETCH;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    adrSrcS    = 1'b0;
    memWriteS  = 1'b0;
    irWriteS   = 1'b0;
    regWriteS  = 1'b0;
    resultSrcS = RES_ALUOUT;
    aluSrcAS   = SRCA_PC;
    aluSrcBS   = SRCB_B;
    aluOp      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        irWriteS   = 1'b1;
        aluSrcBS   = SRCB_FOUR;
        resultSrcS = RES_ALURESULT;
        pcUpdate   = 1'b1;
        nextState  = S_DECODE;
      end
      S_DECODE: begin
        aluSrcAS = SRCA_OLDPC;
        aluSrcBS = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: nextState = S_MEMADR;
          OP_R:              nextState = rLegal ? S_EXECR : S_FETCH;
          OP_IALU:           nextState = S_EXECI;
          OP_JALR:           nextState = S_EXECJALR;
          OP_BRANCH:         nextState = S_BRANCH;
          OP_JAL:            nextState = S_JAL;
          OP_LUI:            nextState = S_LUI;
          default:           nextState = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        aluSrcAS  = SRCA_A;
        aluSrcBS  = SRCB_IMM;
        nextState = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrcS   = 1'b1;
        nextState = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrcS = RES_DATA;
        regWriteS  = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrcS   = 1'b1;
        memWriteS = 1'b1;
      end
      S_EXECR: begin
        aluSrcAS  = SRCA_A;
        aluOp     = ALUOP_FUNCT;
        nextState = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcAS  = SRCA_A;
        aluSrcBS  = SRCB_IMM;
        aluOp     = ALUOP_FUNCT;
        nextState = S_ALUWB;
      end
      S_ALUWB: regWriteS = 1'b1;
      S_BRANCH: begin
        aluSrcAS = SRCA_A;
        aluOp    = ALUOP_SUB;
        branch   = 1'b1;
      end
      // JAL and JALRLINK both load PC from ALUOut and park PC+4 in ALUOut for the link write.
      S_JAL, S_JALRLINK: begin
        aluSrcAS  = SRCA_OLDPC;
        aluSrcBS  = SRCB_FOUR;
        pcUpdate  = 1'b1;
        nextState = S_ALUWB;
      end
      S_EXECJALR: begin
        aluSrcAS  = SRCA_A;
        aluSrcBS  = SRCB_IMM;
        nextState = S_JALRLINK;
      end
      S_LUI: begin
        resultSrcS = RES_IMMEXT;
        regWriteS  = 1'b1;
      end
      default: nextState = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      default: taken = 1'b0;
    endcase
  end

  alu_decoder u_aluDecoder (
    .aluOp      (aluOp),
    .funct3     (funct3),
    .funct7b5   (funct7[5]),
    .opb5       (op[5]),
    .aluControl (aluCtl)
  );

  // Reset gates every output so an aborted instruction leaves no partial write.
  always_comb begin
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regWrite   = 1'b0;
    resultSrc  = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    immSrc     = 3'b000;
    aluControl = 3'b000;
    if (!rst) begin
      pcWrite    = pcUpdate | (branch & taken);
      adrSrc     = adrSrcS;
      memWrite   = memWriteS;
      irWrite    = irWriteS;
      regWrite   = regWriteS;
      resultSrc  = resultSrcS;
      aluSrcA    = aluSrcAS;
      aluSrcB    = aluSrcBS;
      immSrc     = immSrcFor(op);
      aluControl = aluCtl;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] immSrc;
    logic [2:0] aluControl;
  } ctlT;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt;
  ctlT        dut;

  ctlT   expQ[$];
  string tagQ[$];
  int    checks = 0;
  int    errors = 0;
  int    cycleNo = 0;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LW_OP = 7'b0000011,
                         SW_OP = 7'b0100011, B_OP = 7'b1100011, JAL_OP = 7'b1101111,
                         JALR_OP = 7'b1100111, LUI_OP = 7'b0110111;

  always #5 clk = ~clk;

  multicycle_controller u_dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .zero       (zero),
    .lt         (lt),
    .pcWrite    (dut.pcWrite),
    .adrSrc     (dut.adrSrc),
    .memWrite   (dut.memWrite),
    .irWrite    (dut.irWrite),
    .regWrite   (dut.regWrite),
    .resultSrc  (dut.resultSrc),
    .aluSrcA    (dut.aluSrcA),
    .aluSrcB    (dut.aluSrcB),
    .immSrc     (dut.immSrc),
    .aluControl (dut.aluControl)
  );

  function automatic ctlT mk(input logic pcW, input logic adr, input logic memW,
                             input logic irW, input logic regW, input logic [1:0] res,
                             input logic [1:0] a, input logic [1:0] b,
                             input logic [2:0] imm, input logic [2:0] alu);
    ctlT c;
    c = '{pcW, adr, memW, irW, regW, res, a, b, imm, alu};
    return c;
  endfunction

  // ALU operation named by the instruction mnemonic that the funct3 slot encodes.
  function automatic logic [2:0] aluFor(input logic [2:0] f3, input logic isSub);
    case (f3)
      3'd0:    return isSub ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd3:    return 3'd6;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Reference: expected per-cycle control word for one whole instruction.
  task automatic buildExp(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z, input logic l, output ctlT seq[$], output string tag);
    logic [2:0] imm;
    logic       tk;
    ctlT        wb, link;
    seq = {};
    imm = (o == SW_OP) ? 3'd1 : (o == B_OP) ? 3'd2 : (o == JAL_OP) ? 3'd3 :
          (o == LUI_OP) ? 3'd4 : 3'd0;
    wb   = mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, imm, 3'd0);
    link = mk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, imm, 3'd0);
    seq.push_back(mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, imm, 3'd0));
    seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, imm, 3'd0));
    case (o)
      LW_OP: begin
        tag = "lw";
        seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, imm, 3'd0));
        seq.push_back(mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, imm, 3'd0));
        seq.push_back(mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, imm, 3'd0));
      end
      SW_OP: begin
        tag = "sw";
        seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, imm, 3'd0));
        seq.push_back(mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, imm, 3'd0));
      end
      R_OP: begin
        tag = "rtype";
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, imm, aluFor(f3, f7[5])));
          seq.push_back(wb);
        end else tag = "rtype_illegal";
      end
      I_OP: begin
        tag = "itype";
        seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, imm, aluFor(f3, 1'b0)));
        seq.push_back(wb);
      end
      B_OP: begin
        tag = "branch";
        tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? l : (f3 == 3'd5) ? !l : 1'b0;
        seq.push_back(mk(tk, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, imm, 3'd1));
      end
      JAL_OP: begin
        tag = "jal";
        seq.push_back(link);
        seq.push_back(wb);
      end
      JALR_OP: begin
        tag = "jalr";
        seq.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, imm, 3'd0));
        seq.push_back(link);
        seq.push_back(wb);
      end
      LUI_OP: begin
        tag = "lui";
        seq.push_back(mk(0, 0, 0, 0, 1, 2'd3, 2'd0, 2'd0, 3'd4, 3'd0));
      end
      default: tag = "illegal";
    endcase
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // abortAt = cycle index within the instruction at which rst is pulsed, -1 for none.
  task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z, input logic l, input int abortAt);
    ctlT   seq[$];
    string tag;
    buildExp(o, f3, f7, z, l, seq, tag);
    foreach (seq[i]) begin
      nextCycle();
      op = o; funct3 = f3; funct7 = f7; zero = z; lt = l;
      if (i == abortAt) begin
        rst = 1'b1;
        expQ.push_back('0);
        tagQ.push_back({tag, "_rst"});
        break;
      end
      rst = 1'b0;
      expQ.push_back(seq[i]);
      tagQ.push_back($sformatf("%s_c%0d", tag, i + 1));
    end
  endtask

  always @(negedge clk) begin
    cycleNo++;
    if (expQ.size() > 0) begin
      ctlT   e;
      string t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checks++;
      if (dut !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b required %b", t, cycleNo, dut, e);
      end
    end
  end

  initial begin
    logic [6:0] ops[8];
    logic [2:0] rF3[5];
    logic [2:0] iF3[5];
    logic [6:0] o, f7;
    logic [2:0] f3;
    int         abortAt, waitCycles;
    ops = '{R_OP, I_OP, LW_OP, SW_OP, B_OP, JAL_OP, JALR_OP, LUI_OP};
    rF3 = '{3'd0, 3'd2, 3'd3, 3'd6, 3'd7};
    iF3 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6};

    rst = 1'b1; op = '0; funct3 = '0; funct7 = '0; zero = 1'b0; lt = 1'b0;
    repeat (2) begin
      nextCycle();
      expQ.push_back('0);
      tagQ.push_back("reset");
    end

    runInstr(LW_OP, 3'd2, 7'd0, 1'b0, 1'b0, -1);
    runInstr(SW_OP, 3'd2, 7'd0, 1'b0, 1'b0, -1);
    runInstr(B_OP, 3'd0, 7'd0, 1'b1, 1'b0, -1);
    runInstr(B_OP, 3'd0, 7'd0, 1'b0, 1'b0, -1);
    runInstr(B_OP, 3'd5, 7'd0, 1'b0, 1'b0, -1);
    runInstr(R_OP, 3'd0, 7'b0100000, 1'b0, 1'b0, -1);
    runInstr(I_OP, 3'd0, 7'b1111111, 1'b0, 1'b0, -1);
    runInstr(JAL_OP, 3'd0, 7'd0, 1'b0, 1'b0, -1);
    runInstr(LUI_OP, 3'd0, 7'd0, 1'b0, 1'b0, -1);
    runInstr(SW_OP, 3'd2, 7'd0, 1'b0, 1'b0, 3);
    runInstr(7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0, -1);
    runInstr(R_OP, 3'd0, 7'b0000001, 1'b0, 1'b0, -1);

    for (int n = 0; n < 300; n++) begin
      o  = ops[$urandom_range(0, 7)];
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom);
      if (o == R_OP) begin
        f3 = rF3[$urandom_range(0, 4)];
        f7 = ($urandom_range(0, 7) == 0) ? 7'b0000001 :
             (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
      end else if (o == I_OP) begin
        f3 = iF3[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 9) == 0) begin
        o = 7'($urandom);
        if (o inside {R_OP, I_OP, LW_OP, SW_OP, B_OP, JAL_OP, JALR_OP, LUI_OP}) o = 7'b0001111;
      end
      abortAt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      runInstr(o, f3, f7, 1'($urandom), 1'($urandom), abortAt);
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      nextCycle();
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
